// File: rtl/romix_job_driver.sv
// Initiator-side driver for a ROMix core. It takes one job at a time from an
// upstream valid/ready stream, issues it with a single-cycle init pulse, waits
// for the core's valid (or a timeout), then presents the captured result, tags
// and measured latency on a downstream valid/ready stream.
module romix_job_driver #(
   parameter logic [31:0] TIMEOUT_CYCLES = 32'd4000000,
   parameter int unsigned CNT_W          = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              job_valid,
   output logic              job_ready,
   input  logic [1023:0]     job_in,
   input  logic [255:0]      job_ixor,
   input  logic [255:0]      job_oxor,
   output logic              rm_init,
   output logic [1023:0]     rm_in,
   output logic [255:0]      rm_ixor,
   output logic [255:0]      rm_oxor,
   input  logic              rm_ready,
   input  logic              rm_valid,
   input  logic [1023:0]     rm_out,
   input  logic [255:0]      rm_ixor_out,
   input  logic [255:0]      rm_oxor_out,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [1023:0]     res_out,
   output logic [255:0]      res_ixor,
   output logic [255:0]      res_oxor,
   output logic [CNT_W-1:0]  res_cycles,
   output logic              res_timeout,
   output logic [CNT_W-1:0]  jobs_done
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_HOLD
   } state_t;

   // Counter value in the last WAIT cycle before the job is abandoned.
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 32'd1);
   localparam logic [CNT_W-1:0] TIMEOUT_VAL  = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

   state_t           state;
   state_t           state_next;
   logic [CNT_W-1:0] count;

   // State register.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic and handshake decodes; all outputs follow the state register.
   always_comb begin
      state_next = state;
      job_ready  = 1'b0;
      rm_init    = 1'b0;
      res_valid  = 1'b0;
      unique case (state)
         S_IDLE: begin
            job_ready = 1'b1;
            if (job_valid) state_next = S_ISSUE;
         end
         S_ISSUE: begin
            if (rm_ready) begin
               rm_init    = 1'b1;
               state_next = S_WAIT;
            end
         end
         S_WAIT: begin
            if (rm_valid || (count == TIMEOUT_LAST)) state_next = S_HOLD;
         end
         S_HOLD: begin
            res_valid = 1'b1;
            if (res_ready) state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   // Operand latch, latency counter, result capture and completed-job count.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rm_in       <= '0;
         rm_ixor     <= '0;
         rm_oxor     <= '0;
         count       <= '0;
         res_out     <= '0;
         res_ixor    <= '0;
         res_oxor    <= '0;
         res_cycles  <= '0;
         res_timeout <= 1'b0;
         jobs_done   <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (job_valid) begin
                  rm_in   <= job_in;
                  rm_ixor <= job_ixor;
                  rm_oxor <= job_oxor;
               end
            end
            S_ISSUE: begin
               if (rm_ready) count <= '0;
            end
            S_WAIT: begin
               count <= count + CNT_ONE;
               // A valid arriving in the timeout cycle still counts as a real result.
               if (rm_valid) begin
                  res_out     <= rm_out;
                  res_ixor    <= rm_ixor_out;
                  res_oxor    <= rm_oxor_out;
                  res_cycles  <= count + CNT_ONE;
                  res_timeout <= 1'b0;
               end else if (count == TIMEOUT_LAST) begin
                  res_out     <= '0;
                  res_ixor    <= rm_ixor;
                  res_oxor    <= rm_oxor;
                  res_cycles  <= TIMEOUT_VAL;
                  res_timeout <= 1'b1;
               end
            end
            S_HOLD: begin
               if (res_ready) jobs_done <= jobs_done + CNT_ONE;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_romix_job_driver.sv
// Self-checking bench for romix_job_driver. A behavioural ROMix core answers
// the main instance after a programmable latency; a second instance with a
// short timeout is driven directly to exercise the timeout paths.
module tb_romix_job_driver;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          job_valid, job_ready;
   logic [1023:0] job_in;
   logic [255:0]  job_ixor, job_oxor;
   logic          rm_init;
   logic [1023:0] rm_in;
   logic [255:0]  rm_ixor, rm_oxor;
   logic          rm_ready, rm_valid;
   logic [1023:0] rm_out;
   logic [255:0]  rm_ixor_out, rm_oxor_out;
   logic          res_valid, res_ready;
   logic [1023:0] res_out;
   logic [255:0]  res_ixor, res_oxor;
   logic [31:0]   res_cycles;
   logic          res_timeout;
   logic [31:0]   jobs_done;

   logic          to_job_valid, to_job_ready, to_rm_init;
   logic [1023:0] to_rm_in;
   logic [255:0]  to_rm_ixor, to_rm_oxor;
   logic          to_rm_valid;
   logic [1023:0] to_rm_out;
   logic [255:0]  to_rm_ixor_out, to_rm_oxor_out;
   logic          to_res_valid, to_res_ready;
   logic [1023:0] to_res_out;
   logic [255:0]  to_res_ixor, to_res_oxor;
   logic [31:0]   to_res_cycles;
   logic          to_res_timeout;
   logic [31:0]   to_jobs_done;

   always #5 clk = ~clk;

   romix_job_driver #(.TIMEOUT_CYCLES(32'd300), .CNT_W(32)) dut (
      .clk(clk), .reset_n(reset_n),
      .job_valid(job_valid), .job_ready(job_ready),
      .job_in(job_in), .job_ixor(job_ixor), .job_oxor(job_oxor),
      .rm_init(rm_init), .rm_in(rm_in), .rm_ixor(rm_ixor), .rm_oxor(rm_oxor),
      .rm_ready(rm_ready), .rm_valid(rm_valid), .rm_out(rm_out),
      .rm_ixor_out(rm_ixor_out), .rm_oxor_out(rm_oxor_out),
      .res_valid(res_valid), .res_ready(res_ready), .res_out(res_out),
      .res_ixor(res_ixor), .res_oxor(res_oxor), .res_cycles(res_cycles),
      .res_timeout(res_timeout), .jobs_done(jobs_done)
   );

   romix_job_driver #(.TIMEOUT_CYCLES(32'd50), .CNT_W(32)) dut_to (
      .clk(clk), .reset_n(reset_n),
      .job_valid(to_job_valid), .job_ready(to_job_ready),
      .job_in(job_in), .job_ixor(job_ixor), .job_oxor(job_oxor),
      .rm_init(to_rm_init), .rm_in(to_rm_in), .rm_ixor(to_rm_ixor), .rm_oxor(to_rm_oxor),
      .rm_ready(rm_ready), .rm_valid(to_rm_valid), .rm_out(to_rm_out),
      .rm_ixor_out(to_rm_ixor_out), .rm_oxor_out(to_rm_oxor_out),
      .res_valid(to_res_valid), .res_ready(to_res_ready), .res_out(to_res_out),
      .res_ixor(to_res_ixor), .res_oxor(to_res_oxor), .res_cycles(to_res_cycles),
      .res_timeout(to_res_timeout), .jobs_done(to_jobs_done)
   );

   typedef struct {
      logic [1023:0] data;
      logic [255:0]  ixor;
      logic [255:0]  oxor;
      logic [31:0]   cycles;
      logic          timeout;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   core_lat = 100;
   int   init_cnt = 0;

   // Behavioural core transform: swap halves and xor a fixed mask.
   function automatic logic [1023:0] core_fn(input logic [1023:0] x);
      logic [1023:0] m;
      m = {32{32'h5a5ac3c3}};
      return {x[511:0], x[1023:512]} ^ m;
   endfunction

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_blk(input string tag, input logic [1023:0] got, input logic [1023:0] exp);
      for (int i = 0; i < 4; i++)
         check($sformatf("%s[%0d]", tag, i), got[i*256 +: 256], exp[i*256 +: 256]);
   endtask

   task automatic push_exp(input logic [1023:0] d, input logic [255:0] ix, input logic [255:0] ox, input int lat);
      exp_t e;
      e.data = core_fn(d); e.ixor = ix; e.oxor = ox; e.cycles = 32'(lat); e.timeout = 1'b0;
      sb.push_back(e);
   endtask

   task automatic send_job(input logic [1023:0] d, input logic [255:0] ix, input logic [255:0] ox, input bit push);
      bit acc;
      @(posedge clk); #1;
      job_valid = 1'b1; job_in = d; job_ixor = ix; job_oxor = ox;
      acc = 1'b0;
      for (int i = 0; i < 300 && !acc; i++) begin
         @(negedge clk);
         if (job_ready) acc = 1'b1;
      end
      check("job_accept", acc, 1);
      if (acc && push) push_exp(d, ix, ox, core_lat);
      @(posedge clk); #1;
      job_valid = 1'b0;
   endtask

   task automatic wait_drain(input int limit);
      for (int i = 0; i < limit && sb.size() != 0; i++) @(negedge clk);
      check("sb_drained", sb.size(), 0);
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      reset_n = 1'b0; job_valid = 1'b0; to_job_valid = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic release_reset();
      @(posedge clk); #1;
      reset_n = 1'b1;
   endtask

   task automatic check_reset_vals(input string p);
      check({p, "_job_ready"}, job_ready, 1);
      check({p, "_rm_init"}, rm_init, 0);
      check({p, "_res_valid"}, res_valid, 0);
      check({p, "_res_timeout"}, res_timeout, 0);
      check_blk({p, "_res_out"}, res_out, '0);
      check({p, "_res_ixor"}, res_ixor, 0);
      check({p, "_res_oxor"}, res_oxor, 0);
      check_blk({p, "_rm_in"}, rm_in, '0);
      check({p, "_rm_ixor"}, rm_ixor, 0);
      check({p, "_rm_oxor"}, rm_oxor, 0);
      check({p, "_res_cycles"}, res_cycles, 0);
      check({p, "_jobs_done"}, jobs_done, 0);
   endtask

   // Count init pulses seen by the main instance.
   initial forever begin
      @(negedge clk);
      if (rm_init) init_cnt++;
   end

   // Core model: answers each init after core_lat cycles with transformed data.
   initial begin
      logic [1023:0] c_in;
      logic [255:0]  c_ix, c_ox;
      rm_valid = 1'b0; rm_out = '0; rm_ixor_out = '0; rm_oxor_out = '0;
      forever begin
         @(negedge clk);
         if (reset_n && rm_init) begin
            c_in = rm_in; c_ix = rm_ixor; c_ox = rm_oxor;
            repeat (core_lat) @(posedge clk);
            #1;
            rm_valid = 1'b1; rm_out = core_fn(c_in); rm_ixor_out = c_ix; rm_oxor_out = c_ox;
            @(posedge clk); #1;
            rm_valid = 1'b0; rm_out = '0;
         end
      end
   end

   // Result monitor: every downstream handshake pops and compares the scoreboard.
   initial forever begin
      exp_t e;
      @(negedge clk);
      if (reset_n && res_valid && res_ready) begin
         check("sb_nonempty", sb.size() != 0, 1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check_blk("res_out", res_out, e.data);
            check("res_ixor", res_ixor, e.ixor);
            check("res_oxor", res_oxor, e.oxor);
            check("res_cycles", res_cycles, e.cycles);
            check("res_timeout", res_timeout, e.timeout);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1023:0] j1, ja, jb, jc, jd;
      int i0, n;
      bit seen;

      reset_n = 1'b0; job_valid = 1'b0; job_in = '0; job_ixor = '0; job_oxor = '0;
      rm_ready = 1'b1; res_ready = 1'b1;
      to_job_valid = 1'b0; to_rm_valid = 1'b0; to_rm_out = '0;
      to_rm_ixor_out = '0; to_rm_oxor_out = '0; to_res_ready = 1'b0;

      j1 = {32'he9ff2138, {30{32'h0f1e2d3c}}, 16'ha5a5, 16'h2dcf};
      ja = {32{32'h13572468}};
      jb = {32{32'hdeadbeef}};
      jc = {32{32'h0badf00d}};
      jd = {32{32'h600dcafe}};

      // 1: reset, single job with 100-cycle core
      do_reset();
      check_reset_vals("rst1");
      release_reset();
      core_lat = 100;
      i0 = init_cnt;
      send_job(j1, '0, '0, 1'b1);
      seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge clk);
         if (rm_valid) seen = 1'b1;
      end
      check("t1_rm_valid_seen", seen, 1);
      check("t1_res_valid_early", res_valid, 0);
      @(negedge clk);
      check("t1_res_valid_lat", res_valid, 1);
      wait_drain(20);
      check("t1_jobs_done", jobs_done, 1);
      check("t1_init_pulses", init_cnt - i0, 1);

      // 2: core busy for 7 cycles after accept
      core_lat = 20;
      rm_ready = 1'b0;
      i0 = init_cnt;
      send_job(ja, 256'd5, 256'd6, 1'b1);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("t2_init_held", rm_init, 0);
         check("t2_rm_in_stable", rm_in == ja, 1);
      end
      @(posedge clk); #1;
      rm_ready = 1'b1;
      @(negedge clk);
      check("t2_init_pulse", rm_init, 1);
      @(negedge clk);
      check("t2_init_single", rm_init, 0);
      check("t2_rm_in_after", rm_in == ja, 1);
      wait_drain(60);
      check("t2_init_pulses", init_cnt - i0, 1);

      // 3: downstream stalls for 10 cycles in HOLD
      core_lat = 15;
      res_ready = 1'b0;
      send_job(jb, 256'd11, 256'd12, 1'b1);
      seen = 1'b0;
      for (int i = 0; i < 60 && !seen; i++) begin
         @(negedge clk);
         if (res_valid) seen = 1'b1;
      end
      check("t3_res_valid_seen", seen, 1);
      @(posedge clk); #1;
      job_valid = 1'b1; job_in = jc; job_ixor = 256'd21; job_oxor = 256'd22;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("t3_hold_valid", res_valid, 1);
         check("t3_hold_out", res_out == core_fn(jb), 1);
         check("t3_hold_ixor", res_ixor, 11);
         check("t3_hold_cycles", res_cycles, 15);
         check("t3_hold_job_ready", job_ready, 0);
         check("t3_hold_rm_in", rm_in == jb, 1);
      end
      @(posedge clk); #1;
      res_ready = 1'b1;
      @(negedge clk);
      check("t3_job_ready_same", job_ready, 0);
      @(negedge clk);
      check("t3_job_ready_next", job_ready, 1);
      push_exp(jc, 256'd21, 256'd22, core_lat);
      @(posedge clk); #1;
      job_valid = 1'b0;
      wait_drain(60);

      // 4a: short-timeout instance, rm_valid coincides with the timeout cycle
      @(posedge clk); #1;
      to_job_valid = 1'b1; job_in = jc; job_ixor = 256'd7; job_oxor = 256'd8;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (to_job_ready) seen = 1'b1;
      end
      check("t4_accept_a", seen, 1);
      @(posedge clk); #1;
      to_job_valid = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (to_rm_init) seen = 1'b1;
      end
      check("t4_init_a", seen, 1);
      repeat (50) @(posedge clk);
      #1;
      to_rm_valid = 1'b1; to_rm_out = core_fn(jc); to_rm_ixor_out = 256'd7; to_rm_oxor_out = 256'd8;
      @(posedge clk); #1;
      to_rm_valid = 1'b0;
      @(negedge clk);
      check("t4_tie_valid", to_res_valid, 1);
      check("t4_tie_timeout", to_res_timeout, 0);
      check("t4_tie_cycles", to_res_cycles, 50);
      check_blk("t4_tie_out", to_res_out, core_fn(jc));
      @(posedge clk); #1;
      to_res_ready = 1'b1;
      @(posedge clk); #1;
      to_res_ready = 1'b0;

      // 4b: no rm_valid at all, then late valids
      to_job_valid = 1'b1; job_in = jd; job_ixor = 256'd9; job_oxor = 256'd10;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (to_job_ready) seen = 1'b1;
      end
      check("t4_accept_b", seen, 1);
      @(posedge clk); #1;
      to_job_valid = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (to_rm_init) seen = 1'b1;
      end
      check("t4_init_b", seen, 1);
      n = 0;
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         n++;
         if (to_res_valid) seen = 1'b1;
      end
      check("t4_to_latency", n, 51);
      check("t4_to_timeout", to_res_timeout, 1);
      check("t4_to_cycles", to_res_cycles, 50);
      check_blk("t4_to_out", to_res_out, '0);
      check("t4_to_ixor", to_res_ixor, 9);
      check("t4_to_oxor", to_res_oxor, 10);
      @(posedge clk); #1;
      to_rm_valid = 1'b1; to_rm_out = jb; to_rm_ixor_out = 256'd99;
      @(posedge clk); #1;
      to_rm_valid = 1'b0;
      @(negedge clk);
      check("t4_late_hold_timeout", to_res_timeout, 1);
      check("t4_late_hold_ixor", to_res_ixor, 9);
      check_blk("t4_late_hold_out", to_res_out, '0);
      @(posedge clk); #1;
      to_res_ready = 1'b1;
      @(posedge clk); #1;
      to_res_ready = 1'b0;
      to_rm_valid = 1'b1;
      @(posedge clk); #1;
      to_rm_valid = 1'b0;
      n = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (to_res_valid) n++;
      end
      check("t4_no_extra_result", n, 0);
      check("t4_to_jobs_done", to_jobs_done, 2);

      // 5: three back-to-back jobs with downstream always ready
      do_reset();
      release_reset();
      core_lat = 8;
      res_ready = 1'b1;
      for (int k = 1; k <= 3; k++)
         send_job(ja ^ 1024'(k), 256'(k), 256'(k + 100), 1'b1);
      wait_drain(100);
      check("t5_jobs_done", jobs_done, 3);

      // 6: reset in the middle of WAIT, then a normal job
      core_lat = 100;
      send_job(jd, 256'd33, 256'd34, 1'b0);
      repeat (30) @(negedge clk);
      @(posedge clk); #1;
      reset_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_reset_vals("rst6");
      release_reset();
      n = 0;
      for (int i = 0; i < 120; i++) begin
         @(negedge clk);
         if (res_valid) n++;
      end
      check("t6_no_stale_result", n, 0);
      core_lat = 30;
      send_job(jb, 256'd44, 256'd45, 1'b1);
      wait_drain(100);
      check("t6_jobs_done", jobs_done, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
